// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over a raster pixel stream.
// Line buffers plus a column shift register form the window; the MAC is one register stage.
module conv2d_stream #(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int FILTER_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 8,
  parameter int ACC_W        = 20
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [FILTER_SIZE*FILTER_SIZE*COEF_W-1:0]     filter,
  input  logic [DATA_W-1:0]                             pix_in,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  output logic [ACC_W-1:0]                              res_out,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic                                          busy,
  output logic                                          done,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]               row_count,
  output logic [$clog2(IMAGE_WIDTH)-1:0]                col_count
);

  localparam int K   = FILTER_SIZE;
  localparam int CW  = $clog2(IMAGE_WIDTH);
  localparam int RW  = $clog2(IMAGE_HEIGHT);
  localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0]  COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0]  ROW_K1   = RW'(K - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(STRIDE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [K*K*COEF_W-1:0] filt_q;
  logic [DATA_W-1:0]     lb  [K-1][IMAGE_WIDTH];
  logic [DATA_W-1:0]     win [K][K-1];
  logic [DATA_W-1:0]     wf  [K][K];
  logic signed [ACC_W-1:0] sum;

  logic [PHW-1:0] row_ph, col_ph;
  logic accept, hit;
  logic col_last, row_last, last_pix;
  logic col_ge, row_ge;

  assign col_last = (col_count == COL_LAST);
  assign row_last = (row_count == ROW_LAST);
  assign last_pix = col_last && row_last;
  assign col_ge   = (col_count >= COL_K1);
  assign row_ge   = (row_count >= ROW_K1);

  assign pix_ready = (state == RUN) && (!res_valid || res_ready);
  assign accept    = pix_valid && pix_ready;
  assign hit       = accept && row_ge && col_ge &&
                     (row_ph == '0) && (col_ph == '0);

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (accept && last_pix) state_n = FLUSH;
      FLUSH: if (!res_valid || res_ready) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Phases track (pos-(K-1)) mod STRIDE; they sit at 0 until pos reaches K-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_count <= '0;
      col_count <= '0;
      row_ph    <= '0;
      col_ph    <= '0;
    end else if (state == IDLE && start) begin
      row_count <= '0;
      col_count <= '0;
      row_ph    <= '0;
      col_ph    <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_count <= '0;
        col_ph    <= '0;
        if (row_last) begin
          row_count <= '0;
          row_ph    <= '0;
        end else begin
          row_count <= row_count + 1'b1;
          if (!row_ge || row_ph == PH_LAST) row_ph <= '0;
          else                              row_ph <= row_ph + 1'b1;
        end
      end else begin
        col_count <= col_count + 1'b1;
        if (!col_ge || col_ph == PH_LAST) col_ph <= '0;
        else                              col_ph <= col_ph + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) filt_q <= filter;
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        wf[i][j] = win[i][j];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      wf[i][K-1] = lb[i][col_count];
    end
    wf[K-1][K-1] = pix_in;
  end

  // Wrapping ACC_W arithmetic yields the same LSBs as full precision.
  always_comb begin
    sum = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        sum = sum +
          ACC_W'($signed({1'b0, wf[i][j]})) *
          ACC_W'($signed(filt_q[(i*K+j)*COEF_W +: COEF_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 2; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][K-2] <= wf[i][K-1];
      end
      for (int i = 0; i < K - 2; i++) begin
        lb[i][col_count] <= lb[i+1][col_count];
      end
      lb[K-2][col_count] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_out   <= '0;
    end else if (hit) begin
      res_valid <= 1'b1;
      res_out   <= sum;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: directed and random frames against a
// window-sum reference model.
module tb_conv2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic        pix_valid, pix_valid2, res_ready;
  logic [71:0] filter;
  logic [7:0]  pix_in;

  logic        pr1, rv1, busy1, done1;
  logic [19:0] ro1;
  logic [2:0]  rc1, cc1;
  logic        pr2, rv2, busy2, done2;
  logic [19:0] ro2;
  logic [2:0]  rc2, cc2;

  conv2d_stream #(.STRIDE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .filter(filter),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pr1),
    .res_out(ro1), .res_valid(rv1), .res_ready(res_ready),
    .busy(busy1), .done(done1), .row_count(rc1), .col_count(cc1)
  );

  conv2d_stream #(.STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .filter(filter),
    .pix_in(pix_in), .pix_valid(pix_valid2), .pix_ready(pr2),
    .res_out(ro2), .res_valid(rv2), .res_ready(res_ready),
    .busy(busy2), .done(done2), .row_count(rc2), .col_count(cc2)
  );

  int checks = 0;
  int failures = 0;
  int img[25];
  int flt[9];
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [71:0] pack_filter();
    logic [71:0] f;
    for (int k = 0; k < 9; k++) f[k*8 +: 8] = 8'(flt[k]);
    return f;
  endfunction

  // Reference: every output window in raster order, plain integer sums.
  task automatic build_exp(input int s);
    int n, sm, r0, c0;
    exp_q.delete();
    n = (5 - 3) / s + 1;
    for (int orow = 0; orow < n; orow++) begin
      for (int ocol = 0; ocol < n; ocol++) begin
        r0 = orow * s;
        c0 = ocol * s;
        sm = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            sm += flt[i*3+j] * img[(r0+i)*5 + c0 + j];
        exp_q.push_back(20'(sm));
      end
    end
  endtask

  function automatic bit hitpos(input int idx, input int s);
    int r, c;
    r = idx / 5;
    c = idx % 5;
    return (r >= 2) && (c >= 2) && ((r-2) % s == 0) && ((c-2) % s == 0);
  endfunction

  task automatic run_frame(input int sel, input int rmode,
                           input bit vgaps, input bit start_mid);
    int idx, got, cyc, s, n;
    bit fin, done_seen, prev_stall, exp_rv, pv, acc, hs, rr;
    logic [19:0] prev_out, ev;
    logic pr, rv, dn, bz;
    logic [19:0] ro;
    logic [2:0] rc, cc;
    int pat[4] = '{1, 0, 0, 1};

    s = sel ? 2 : 1;
    filter = pack_filter();
    build_exp(s);
    n = exp_q.size();
    idx = 0; got = 0; cyc = 0;
    fin = 0; done_seen = 0; prev_stall = 0; exp_rv = 0;
    prev_out = '0;
    res_ready = 1'b1;

    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;

    while (!done_seen && cyc < 3000) begin
      pv = (idx < 25) && (!vgaps || $urandom_range(0, 3) != 0);
      pix_in = 8'(img[(idx < 25) ? idx : 0]);
      if (sel) pix_valid2 = pv; else pix_valid = pv;
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = pat[cyc % 4][0];
        default: rr = $urandom_range(0, 1) == 1;
      endcase
      res_ready = rr;
      if (!sel) start = start_mid && (cyc == 7);

      @(negedge clk);
      pr = sel ? pr2 : pr1;
      rv = sel ? rv2 : rv1;
      ro = sel ? ro2 : ro1;
      dn = sel ? done2 : done1;
      bz = sel ? busy2 : busy1;
      rc = sel ? rc2 : rc1;
      cc = sel ? cc2 : cc1;

      check("done", {31'd0, dn}, {31'd0, fin});
      if (fin) done_seen = 1;
      check("res_valid", {31'd0, rv}, {31'd0, exp_rv});
      if (rv) begin
        ev = (got < n) ? exp_q[got] : 20'hfffff;
        check("res_out", {12'd0, ro}, {12'd0, ev});
      end
      if (prev_stall) check("stall_hold", {12'd0, ro}, {12'd0, prev_out});
      if (rv && !rr) check("stall_ready", {31'd0, pr}, 32'd0);
      if (idx < 25) begin
        check("busy", {31'd0, bz}, 32'd1);
        check("row_count", {29'd0, rc}, 32'(idx / 5));
        check("col_count", {29'd0, cc}, 32'(idx % 5));
      end

      acc = pv && pr;
      hs = rv && rr;
      exp_rv = (acc && hitpos(idx, s)) || (rv && !rr);
      if (hs) begin
        got++;
        if (got == n) fin = 1;
      end
      prev_stall = rv && !rr;
      prev_out = ro;
      if (acc) idx++;
      cyc++;
      @(posedge clk); #1;
    end

    start = 1'b0;
    pix_valid = 1'b0;
    pix_valid2 = 1'b0;
    check("frame_done_seen", {31'd0, done_seen}, 32'd1);
    check("result_count", 32'(got), 32'(n));
    @(negedge clk);
    check("done_drop", {31'd0, sel ? done2 : done1}, 32'd0);
    check("idle_busy", {31'd0, sel ? busy2 : busy1}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_ramp_ones();
    for (int k = 0; k < 25; k++) img[k] = k + 1;
    for (int k = 0; k < 9; k++) flt[k] = 1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    pix_valid = 1'b0;
    pix_valid2 = 1'b0;
    res_ready = 1'b1;
    pix_in = '0;
    filter = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pix_ready", {31'd0, pr1}, 32'd0);
    check("rst_res_valid", {31'd0, rv1}, 32'd0);
    check("rst_res_out", {12'd0, ro1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_rows_cols", {26'd0, rc1, cc1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    set_ramp_ones();
    run_frame(0, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(1, 0, 0, 0);

    for (int k = 0; k < 9; k++) flt[k] = 0;
    flt[4] = -1;
    run_frame(0, 0, 0, 0);

    set_ramp_ones();
    filter = pack_filter();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pix_in = 8'(img[k]);
      pix_valid = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_pix_ready", {31'd0, pr1}, 32'd0);
    check("mid_rst_res_valid", {31'd0, rv1}, 32'd0);
    check("mid_rst_res_out", {12'd0, ro1}, 32'd0);
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_done", {31'd0, done1}, 32'd0);
    check("mid_rst_rows_cols", {26'd0, rc1, cc1}, 32'd0);
    @(posedge clk); #1;
    run_frame(0, 0, 0, 0);

    for (int k = 0; k < 25; k++) img[k] = int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) flt[k] = int'($urandom_range(0, 255)) - 128;
    run_frame(0, 2, 1, 1);
    run_frame(0, 2, 1, 0);
    run_frame(1, 2, 1, 0);

    for (int k = 0; k < 25; k++) img[k] = 255;
    for (int k = 0; k < 9; k++) flt[k] = -128;
    run_frame(0, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
